// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage for the parallel FFT pipeline.
// Frames arrive LANES samples per beat in bit-reversed order. They are written into one of two
// ping-pong banks at bit-reversed addresses, then read back in natural order. A per-frame
// bypass bit, latched on beat 0, stores the frame in arrival order instead.
// Reads go through one staging register ahead of the output register. This gives a two-edge
// latency from the last input beat to output beat 0. It also frees a bank as soon as its last
// beat is staged, so full-rate streaming never stalls the writer.
module fft_bitrev_reorder #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned LANES  = 16,
    parameter int unsigned NPOINT = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic signed [WIDTH-1:0] din_re [LANES],
    input  logic signed [WIDTH-1:0] din_im [LANES],
    input  logic                    bypass,
    output logic                    do_en,
    input  logic                    do_ready,
    output logic signed [WIDTH-1:0] do_re [LANES],
    output logic signed [WIDTH-1:0] do_im [LANES],
    output logic                    do_first,
    output logic                    do_last
);
    localparam int unsigned LOG2N = $clog2(NPOINT);
    localparam int unsigned BEATS = NPOINT / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    logic signed [WIDTH-1:0] mem_re [2][NPOINT];
    logic signed [WIDTH-1:0] mem_im [2][NPOINT];

    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [BW-1:0] wr_beat_q, wr_beat_d;
    logic [BW-1:0] rd_beat_q, rd_beat_d;

    // Read staging register between the bank and the output register
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_first_q, s1_last_q;
    logic signed [WIDTH-1:0] s1_re_q [LANES];
    logic signed [WIDTH-1:0] s1_im_q [LANES];

    logic             wr_fire, wr_last, wr_mode;
    logic             rd_fire, rd_last, s1_adv, out_load;
    logic [LOG2N-1:0] wr_lin  [LANES];
    logic [LOG2N-1:0] wr_addr [LANES];
    logic [LOG2N-1:0] rd_base;

    // Handshakes and write/read address decode
    always_comb begin
        din_ready = !rst && !full_q[wr_bank_q];
        wr_fire   = din_valid && din_ready;
        wr_last   = (wr_beat_q == LAST_BEAT);
        // On beat 0 the mode bit is being captured this cycle, so use bypass directly
        wr_mode   = (wr_beat_q == '0) ? bypass : mode_q[wr_bank_q];
        out_load  = s1_valid_q && (!do_en || do_ready);
        s1_adv    = !s1_valid_q || out_load;
        rd_fire   = full_q[rd_bank_q] && s1_adv;
        rd_last   = (rd_beat_q == LAST_BEAT);
        for (int l = 0; l < int'(LANES); l++) begin
            wr_lin[l]  = LOG2N'(wr_beat_q) * LOG2N'(LANES) + LOG2N'(l);
            wr_addr[l] = wr_mode ? wr_lin[l] : bitrev(wr_lin[l]);
        end
        rd_base = LOG2N'(rd_beat_q) * LOG2N'(LANES);
    end

    // Bank bookkeeping; set and clear always target different banks
    always_comb begin
        full_d     = full_q;
        mode_d     = mode_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_beat_d  = wr_beat_q;
        rd_beat_d  = rd_beat_q;
        s1_valid_d = s1_valid_q;
        if (wr_fire) begin
            if (wr_beat_q == '0) begin
                mode_d[wr_bank_q] = bypass;
            end
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_beat_d         = '0;
            end else begin
                wr_beat_d = wr_beat_q + BW'(1);
            end
        end
        if (rd_fire) begin
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_beat_d         = '0;
            end else begin
                rd_beat_d = rd_beat_q + BW'(1);
            end
        end
        if (rd_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Control state registers, synchronous reset discards any partial or unread frame
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            mode_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_beat_q  <= '0;
            rd_beat_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            mode_q     <= mode_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_beat_q  <= wr_beat_d;
            rd_beat_q  <= rd_beat_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    // Bank writes; storage contents are never reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int l = 0; l < int'(LANES); l++) begin
                mem_re[wr_bank_q][wr_addr[l]] <= din_re[l];
                mem_im[wr_bank_q][wr_addr[l]] <= din_im[l];
            end
        end
    end

    // Natural-order bank read into the staging register
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            for (int l = 0; l < int'(LANES); l++) begin
                s1_re_q[l] <= mem_re[rd_bank_q][rd_base + LOG2N'(l)];
                s1_im_q[l] <= mem_im[rd_bank_q][rd_base + LOG2N'(l)];
            end
            s1_first_q <= (rd_beat_q == '0);
            s1_last_q  <= rd_last;
        end
    end

    // Output register; everything holds while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            do_en    <= 1'b0;
            do_first <= 1'b0;
            do_last  <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                do_re[l] <= '0;
                do_im[l] <= '0;
            end
        end else if (out_load) begin
            do_en    <= 1'b1;
            do_first <= s1_first_q;
            do_last  <= s1_last_q;
            for (int l = 0; l < int'(LANES); l++) begin
                do_re[l] <= s1_re_q[l];
                do_im[l] <= s1_im_q[l];
            end
        end else if (do_ready) begin
            do_en <= 1'b0;
        end
    end

endmodule
